// File: rtl/sev_clock_hms_if.sv
// rtl/sev_clock_hms_if.sv - control inputs and display/pulse outputs of the HH:MM:SS clock
interface sev_clock_hms_if;
  logic       en;
  logic       mode12;
  logic       set_en;
  logic [4:0] set_h;
  logic [5:0] set_m;
  logic [6:0] oh1, oh0, om1, om0, os1, os0;
  logic       pm;
  logic       sec_tick;
  logic       day_tick;
  logic       set_err;

  modport master (
    output en, mode12, set_en, set_h, set_m,
    input  oh1, oh0, om1, om0, os1, os0, pm, sec_tick, day_tick, set_err
  );

  modport slave (
    input  en, mode12, set_en, set_h, set_m,
    output oh1, oh0, om1, om0, os1, os0, pm, sec_tick, day_tick, set_err
  );
endinterface

// File: rtl/sev_clock_hms.sv
// rtl/sev_clock_hms.sv - HH:MM:SS clock with prescaled tick, time load, 12/24h seven-segment display
module sev_clock_hms #(
  parameter int CLK_DIV        = 50_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit LEAD_BLANK     = 1'b0
) (
  input logic            clk,
  input logic            rst,
  sev_clock_hms_if.slave bus
);
  localparam int            PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [6:0]    SEG_MASK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0]    SEG_ZERO = 7'h3F ^ SEG_MASK;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] c;
    case (v)
      4'd0:    c = 7'h3F;
      4'd1:    c = 7'h06;
      4'd2:    c = 7'h5B;
      4'd3:    c = 7'h4F;
      4'd4:    c = 7'h66;
      4'd5:    c = 7'h6D;
      4'd6:    c = 7'h7D;
      4'd7:    c = 7'h07;
      4'd8:    c = 7'h7F;
      4'd9:    c = 7'h6F;
      default: c = 7'h00;
    endcase
    return c ^ SEG_MASK;
  endfunction

  function automatic logic [3:0] tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] units(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  logic [4:0]    h_q, h_d;
  logic [5:0]    m_q, m_d, s_q, s_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          sec_tick_q, sec_tick_d, day_tick_q, day_tick_d, set_err_q, set_err_d;
  logic          pm_q, pm_d;
  logic [6:0]    oh1_q, oh1_d, oh0_q, oh0_d, om1_q, om1_d, om0_q, om0_d, os1_q, os1_d, os0_q, os0_d;
  logic          tick, load_ok;
  logic [4:0]    h_disp;

  // A load request, valid or not, owns the edge: the coincident tick is dropped.
  always_comb begin
    tick       = bus.en && (pre_q == PRE_LAST);
    load_ok    = (bus.set_h <= 5'd23) && (bus.set_m <= 6'd59);
    h_d        = h_q;
    m_d        = m_q;
    s_d        = s_q;
    pre_d      = pre_q;
    sec_tick_d = 1'b0;
    day_tick_d = 1'b0;
    set_err_d  = 1'b0;
    if (bus.set_en) begin
      if (load_ok) begin
        h_d   = bus.set_h;
        m_d   = bus.set_m;
        s_d   = '0;
        pre_d = '0;
      end else begin
        set_err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (tick) begin
        pre_d      = '0;
        sec_tick_d = 1'b1;
        if (s_q == 6'd59) begin
          s_d = '0;
          if (m_q == 6'd59) begin
            m_d = '0;
            if (h_q == 5'd23) begin
              h_d        = '0;
              day_tick_d = 1'b1;
            end else begin
              h_d = h_q + 5'd1;
            end
          end else begin
            m_d = m_q + 6'd1;
          end
        end else begin
          s_d = s_q + 6'd1;
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Display path decodes the current counters, so it trails them by one edge.
  always_comb begin
    h_disp = h_q;
    if (bus.mode12) begin
      if (h_q == 5'd0) begin
        h_disp = 5'd12;
      end else if (h_q > 5'd12) begin
        h_disp = h_q - 5'd12;
      end
    end
    pm_d  = (h_q >= 5'd12);
    oh1_d = (LEAD_BLANK && bus.mode12 && (h_disp < 5'd10)) ? seg7(4'hF) : seg7(tens(6'(h_disp)));
    oh0_d = seg7(units(6'(h_disp)));
    om1_d = seg7(tens(m_q));
    om0_d = seg7(units(m_q));
    os1_d = seg7(tens(s_q));
    os0_d = seg7(units(s_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q        <= '0;
      m_q        <= '0;
      s_q        <= '0;
      pre_q      <= '0;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
      pm_q       <= 1'b0;
      oh1_q      <= SEG_ZERO;
      oh0_q      <= SEG_ZERO;
      om1_q      <= SEG_ZERO;
      om0_q      <= SEG_ZERO;
      os1_q      <= SEG_ZERO;
      os0_q      <= SEG_ZERO;
    end else begin
      h_q        <= h_d;
      m_q        <= m_d;
      s_q        <= s_d;
      pre_q      <= pre_d;
      sec_tick_q <= sec_tick_d;
      day_tick_q <= day_tick_d;
      set_err_q  <= set_err_d;
      pm_q       <= pm_d;
      oh1_q      <= oh1_d;
      oh0_q      <= oh0_d;
      om1_q      <= om1_d;
      om0_q      <= om0_d;
      os1_q      <= os1_d;
      os0_q      <= os0_d;
    end
  end

  assign bus.oh1      = oh1_q;
  assign bus.oh0      = oh0_q;
  assign bus.om1      = om1_q;
  assign bus.om0      = om0_q;
  assign bus.os1      = os1_q;
  assign bus.os0      = os0_q;
  assign bus.pm       = pm_q;
  assign bus.sec_tick = sec_tick_q;
  assign bus.day_tick = day_tick_q;
  assign bus.set_err  = set_err_q;
endmodule
